// File: rtl/bus_timer_array.sv
// Bus-mapped array of NUM_CH 16-bit down-counting timers sharing one tick prescaler.
// Channel pending flags combine into a single registered interrupt raise/ack pair.
module bus_timer_array #(
  parameter logic [7:0]  BASE_ADDR   = 8'hD0,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned TICK_HZ     = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int unsigned Div     = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned PrescW  = $clog2(Div);
  localparam int unsigned GlobOff = 4 * NUM_CH;

  logic [PrescW-1:0] presc_q, presc_d;
  logic              tick;

  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] ie_q, ie_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [15:0]       period_q [NUM_CH];
  logic [15:0]       period_d [NUM_CH];
  logic [15:0]       count_q  [NUM_CH];
  logic [15:0]       count_d  [NUM_CH];

  logic [7:0]        count_hi_q, count_hi_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_en_q, rd_en_d;
  logic              raise_q, raise_d;

  logic [7:0]        offset;
  logic [7:0]        wdata;
  logic [31:0]       off32;
  logic              in_range, rd_hit, wr_hit;
  logic [NUM_CH-1:0] wr_ctrl, load, expire, clr;

  // A programmed period of zero behaves as a period of one tick.
  function automatic logic [15:0] reload_val(input logic [15:0] period);
    return (period == 16'd0) ? 16'd1 : period;
  endfunction

  assign offset   = BUS_ADDR - BASE_ADDR;
  assign off32    = {24'd0, offset};
  assign in_range = (BUS_ADDR >= BASE_ADDR) && (off32 <= GlobOff + 32'd1);
  assign rd_hit   = in_range && !BUS_WE;
  assign wr_hit   = in_range && BUS_WE;
  assign wdata    = BUS_DATA;
  assign tick     = (presc_q == PrescW'(Div - 1));

  always_comb begin
    presc_d  = tick ? '0 : presc_q + PrescW'(1);
    en_d     = en_q;
    mode_d   = mode_q;
    ie_d     = ie_q;
    period_d = period_q;
    count_d  = count_q;
    wr_ctrl  = '0;
    load     = '0;
    expire   = '0;
    clr      = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      wr_ctrl[c] = wr_hit && (off32 == 4 * c);
      load[c]    = wr_ctrl[c] && ((wdata[0] && !en_q[c]) || wdata[3]);
      // A load on a tick edge suppresses that tick's decrement and expiry.
      if (tick && en_q[c] && !load[c]) begin
        if (count_q[c] <= 16'd1) begin
          expire[c] = 1'b1;
          if (mode_q[c]) begin
            count_d[c] = reload_val(period_q[c]);
          end else begin
            count_d[c] = '0;
            en_d[c]    = 1'b0;
          end
        end else begin
          count_d[c] = count_q[c] - 16'd1;
        end
      end
      if (wr_ctrl[c]) begin
        en_d[c]   = wdata[0];
        mode_d[c] = wdata[1];
        ie_d[c]   = wdata[2];
      end
      if (load[c]) begin
        count_d[c] = reload_val(period_q[c]);
      end
      if (wr_hit && (off32 == 4 * c + 1)) begin
        period_d[c][7:0] = wdata;
      end
      if (wr_hit && (off32 == 4 * c + 2)) begin
        period_d[c][15:8] = wdata;
      end
      clr[c] = (BUS_INTERRUPT_ACK && ie_q[c]) || (wr_hit && (off32 == GlobOff) && wdata[c]);
    end
    // A new expiry outranks any clear on the same edge.
    pending_d = (pending_q & ~clr) | expire;
    raise_d   = |(pending_q & ie_q);
  end

  always_comb begin
    rd_data_d  = '0;
    rd_en_d    = rd_hit;
    count_hi_d = count_hi_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (off32 == 4 * c) begin
        rd_data_d = {5'd0, ie_q[c], mode_q[c], en_q[c]};
      end
      if (off32 == 4 * c + 1) begin
        rd_data_d = period_q[c][7:0];
      end
      if (off32 == 4 * c + 2) begin
        rd_data_d = period_q[c][15:8];
      end
      if (off32 == 4 * c + 3) begin
        rd_data_d = count_q[c][7:0];
        if (rd_hit) begin
          count_hi_d = count_q[c][15:8];
        end
      end
    end
    if (off32 == GlobOff) begin
      rd_data_d = 8'(pending_q);
    end
    if (off32 == GlobOff + 32'd1) begin
      rd_data_d = count_hi_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q    <= '0;
      en_q       <= '0;
      mode_q     <= '0;
      ie_q       <= '0;
      pending_q  <= '0;
      count_hi_q <= '0;
      rd_data_q  <= '0;
      rd_en_q    <= 1'b0;
      raise_q    <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        period_q[c] <= '0;
        count_q[c]  <= '0;
      end
    end else begin
      presc_q    <= presc_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      ie_q       <= ie_d;
      pending_q  <= pending_d;
      count_hi_q <= count_hi_d;
      rd_data_q  <= rd_data_d;
      rd_en_q    <= rd_en_d;
      raise_q    <= raise_d;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        period_q[c] <= period_d[c];
        count_q[c]  <= count_d[c];
      end
    end
  end

  assign BUS_DATA            = rd_en_q ? rd_data_q : 8'hzz;
  assign BUS_INTERRUPT_RAISE = raise_q;

endmodule

// File: tb/tb_bus_timer_array.sv
// Bench for bus_timer_array: directed scenarios plus random bus traffic, with every
// cycle's read data, bus release and interrupt line compared to a behavioural model.
module tb_bus_timer_array;

  localparam logic [7:0] Base = 8'hD0;
  localparam int         NCh  = 4;
  localparam int         Div  = 10;
  localparam logic [7:0] Idle = 8'h00;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       we     = 1'b0;
  logic       ack    = 1'b0;
  logic       drv_en = 1'b0;
  logic [7:0] addr   = Idle;
  logic [7:0] drv    = 8'h00;
  logic       raise;
  wire  [7:0] bus_data;

  assign bus_data = drv_en ? drv : 8'hzz;
  always #5 clk = ~clk;

  bus_timer_array #(
    .BASE_ADDR  (Base),
    .NUM_CH     (NCh),
    .CLK_FREQ_HZ(1000),
    .TICK_HZ    (100)
  ) dut (
    .CLK                (clk),
    .RST                (rst),
    .BUS_ADDR           (addr),
    .BUS_DATA           (bus_data),
    .BUS_WE             (we),
    .BUS_INTERRUPT_RAISE(raise),
    .BUS_INTERRUPT_ACK  (ack)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_on  = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural model of the register file, timers and interrupt line.
  int         m_cnt [NCh];
  int         m_per [NCh];
  bit         m_en  [NCh];
  bit         m_mode[NCh];
  bit         m_ie  [NCh];
  bit         m_pend[NCh];
  int         m_presc = 0;
  logic [7:0] m_hi    = 8'h00;
  logic [7:0] m_rd    = 8'h00;
  bit         m_rd_v  = 1'b0;
  bit         m_raise = 1'b0;

  function automatic logic [7:0] reg_read(input int off);
    logic [7:0] v;
    v = 8'h00;
    if (off < 4 * NCh) begin
      case (off % 4)
        0:       v = {5'd0, m_ie[off/4], m_mode[off/4], m_en[off/4]};
        1:       v = 8'(m_per[off/4]);
        2:       v = 8'(m_per[off/4] >> 8);
        default: v = 8'(m_cnt[off/4]);
      endcase
    end else if (off == 4 * NCh) begin
      for (int c = 0; c < NCh; c++) v[c] = m_pend[c];
    end else begin
      v = m_hi;
    end
    return v;
  endfunction

  task automatic model_step();
    int off, per1;
    bit inr, tick, ld, ex, wctl, clr, raise_n;
    if (rst) begin
      for (int c = 0; c < NCh; c++) begin
        m_en[c] = 0; m_mode[c] = 0; m_ie[c] = 0; m_pend[c] = 0; m_per[c] = 0; m_cnt[c] = 0;
      end
      m_presc = 0; m_hi = 8'h00; m_rd = 8'h00; m_rd_v = 0; m_raise = 0;
      return;
    end
    off = int'(addr) - int'(Base);
    inr = (off >= 0) && (off <= 4 * NCh + 1);
    raise_n = 0;
    for (int c = 0; c < NCh; c++) raise_n |= m_pend[c] & m_ie[c];
    m_rd_v = !we && inr;
    if (m_rd_v) begin
      m_rd = reg_read(off);
      if (off < 4 * NCh && off % 4 == 3) m_hi = 8'(m_cnt[off/4] >> 8);
    end
    tick    = (m_presc == Div - 1);
    m_presc = (m_presc + 1) % Div;
    for (int c = 0; c < NCh; c++) begin
      wctl = we && inr && (off == 4 * c);
      ld   = wctl && ((drv[0] && !m_en[c]) || drv[3]);
      per1 = (m_per[c] == 0) ? 1 : m_per[c];
      clr  = (ack && m_ie[c]) || (we && inr && (off == 4 * NCh) && drv[c]);
      ex   = 0;
      if (tick && m_en[c] && !ld) begin
        if (m_cnt[c] <= 1) begin
          ex = 1;
          if (m_mode[c]) m_cnt[c] = per1;
          else begin m_cnt[c] = 0; m_en[c] = 0; end
        end else begin
          m_cnt[c]--;
        end
      end
      if (wctl) begin m_en[c] = drv[0]; m_mode[c] = drv[1]; m_ie[c] = drv[2]; end
      if (ld) m_cnt[c] = per1;
      if (we && inr && off == 4 * c + 1) m_per[c] = (m_per[c] & 'hFF00) | int'(drv);
      if (we && inr && off == 4 * c + 2) m_per[c] = (m_per[c] & 'h00FF) | (int'(drv) << 8);
      m_pend[c] = ex || (m_pend[c] && !clr);
    end
    m_raise = raise_n;
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    model_step();
  end

  // Continuous cycle check of interrupt line, read data and bus release.
  always @(negedge clk) begin
    #1;
    if (chk_on) begin
      check("raise", 16'(raise), 16'(m_raise));
      if (m_rd_v) check("rdata", 16'(bus_data), 16'(m_rd));
      else if (!drv_en) check("float", 16'(bus_data === 8'hzz), 16'd1);
    end
  end

  // All bus tasks start and end just after a falling edge.
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; drv = d; drv_en = 1'b1; we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0; drv_en = 1'b0; addr = Idle;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    addr = a; we = 1'b0;
    @(posedge clk);
    #1 d = bus_data;
    @(negedge clk);
    addr = Idle;
    @(negedge clk);
  endtask

  task automatic bus_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rst_pulse(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_raise(input int limit, output int n, output int at);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!raise && n < limit);
    at = cyc;
    check("raise_wait", 16'(raise), 16'd1);
    @(negedge clk);
  endtask

  logic [7:0] d, lo, hi;
  int n, r1, r2, k, snap, r;
  logic [7:0] a;

  initial begin
    // Reset and idle register state.
    rst_pulse(3);
    chk_on = 1'b1;
    check("rst_float", 16'(bus_data === 8'hzz), 16'd1);
    check("rst_raise", 16'(raise), 16'd0);
    for (int i = 'hD0; i <= 'hE1; i++) begin
      bus_read(8'(i), d);
      check("rst_reg", 16'(d), 16'h00);
    end

    // Periodic ch1, period 3 ticks.
    bus_write(8'hD5, 8'd3);
    bus_write(8'hD6, 8'd0);
    bus_write(8'hD4, 8'h07);
    wait_raise(40, n, r1);
    check("per_first", 16'((n >= 22) && (n <= 31)), 16'd1);
    bus_read(8'hE0, d);
    check("per_pend", 16'(d), 16'h02);
    bus_ack();
    idle(1);
    check("per_ackraise", 16'(raise), 16'd0);
    wait_raise(40, n, r2);
    check("per_interval", 16'(r2 - r1), 16'd30);
    bus_write(8'hD4, 8'h00);
    bus_write(8'hE0, 8'hFF);
    idle(2);
    check("per_off", 16'(raise), 16'd0);

    // One-shot ch0, period 0x0102.
    bus_write(8'hD1, 8'h02);
    bus_write(8'hD2, 8'h01);
    bus_write(8'hD0, 8'h05);
    wait_raise(2700, n, r1);
    check("os_time", 16'((n >= 2572) && (n <= 2581)), 16'd1);
    bus_read(8'hD0, d);
    check("os_ctrl", 16'(d), 16'h04);
    bus_read(8'hD3, d);
    check("os_count", 16'(d), 16'h00);
    bus_read(8'hE0, d);
    check("os_pend", 16'(d), 16'h01);
    bus_ack();
    idle(60);
    check("os_raise", 16'(raise), 16'd0);
    bus_read(8'hE0, d);
    check("os_nopend", 16'(d), 16'h00);

    // Atomic 16-bit count read on ch2.
    bus_write(8'hD9, 8'h00);
    bus_write(8'hDA, 8'h03);
    bus_write(8'hD8, 8'h01);
    for (int i = 0; i < 12; i++) begin
      idle($urandom_range(0, 9));
      snap = m_cnt[2];
      bus_read(8'hDB, lo);
      bus_read(8'hE1, hi);
      check("atomic", {hi, lo}, 16'(snap));
    end
    bus_write(8'hD8, 8'h00);
    bus_write(8'hE0, 8'hFF);

    // Masked ch3: pending without raise, immune to ACK, W1C and set-wins.
    bus_write(8'hDD, 8'd2);
    bus_write(8'hDE, 8'd0);
    bus_write(8'hDC, 8'h03);
    k = 0;
    do begin
      bus_read(8'hE0, d);
      k++;
    end while (!d[3] && k < 20);
    check("mask_pend", 16'(d[3]), 16'd1);
    check("mask_raise", 16'(raise), 16'd0);
    bus_ack();
    bus_read(8'hE0, d);
    check("mask_ack", 16'(d[3]), 16'd1);
    k = 0;
    while (!(m_presc == Div - 1 && m_en[3] && m_cnt[3] <= 1) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("setwin_sync", 16'(k < 40), 16'd1);
    bus_write(8'hE0, 8'h08);
    bus_read(8'hE0, d);
    check("setwin", 16'(d[3]), 16'd1);
    bus_write(8'hDC, 8'h00);
    bus_write(8'hE0, 8'h08);
    bus_read(8'hE0, d);
    check("w1c", 16'(d), 16'h00);

    // Reset during a running periodic count.
    bus_write(8'hD5, 8'd3);
    bus_write(8'hD6, 8'd0);
    bus_write(8'hD4, 8'h07);
    idle(37);
    rst_pulse(1);
    check("mid_raise", 16'(raise), 16'd0);
    for (int i = 'hD0; i <= 'hE1; i++) begin
      bus_read(8'(i), d);
      check("mid_reg", 16'(d), 16'h00);
    end
    idle(60);
    check("mid_quiet", 16'(raise), 16'd0);
    bus_read(8'hE0, d);
    check("mid_pend", 16'(d), 16'h00);

    // Random bus traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        k = $urandom_range(0, NCh - 1);
        case ($urandom_range(0, 3))
          0:       bus_write(Base + 8'(4 * k), 8'($urandom));
          1:       bus_write(Base + 8'(4 * k + 1), 8'($urandom_range(0, 6)));
          2:       bus_write(Base + 8'(4 * k + 2), ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0);
          default: bus_write(Base + 8'(4 * k + 3), 8'($urandom));
        endcase
      end else if (r < 35) begin
        a = $urandom_range(0, 1) ? 8'($urandom_range(0, 'hCF)) : 8'($urandom_range('hE2, 'hFF));
        bus_write(a, 8'($urandom));
      end else if (r < 40) begin
        bus_write(Base + 8'(4 * NCh + $urandom_range(0, 1)), 8'($urandom));
      end else if (r < 75) begin
        bus_read(Base + 8'($urandom_range(0, 4 * NCh + 1)), d);
      end else if (r < 78) begin
        bus_read(8'($urandom_range('hE2, 'hFF)), d);
      end else if (r < 88) begin
        bus_ack();
      end else if (r < 99) begin
        idle($urandom_range(1, 8));
      end else begin
        rst_pulse(1);
      end
    end

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_timer_array.md
Name: bus_timer_array

Overview:
- Bus-mapped timer peripheral with NUM_CH independent 16-bit down-counting channels, sharing one free-running tick prescaler.
- Each channel has a one-shot or periodic mode and its own interrupt enable.
- Pending interrupts from all channels combine into one raise/ack pair on the CPU interrupt bus.
- Sits on the shared 8-bit CPU data/address bus alongside RAM, the IR transmitter and the switch peripheral. It is the generalised successor of the single-channel timer.

Parameters:
- BASE_ADDR, 8'hD0, first bus address of the register block.
- NUM_CH, 4, number of channels; legal range 1..8.
- CLK_FREQ_HZ, 50000000, CLK frequency.
- TICK_HZ, 1000, tick rate. DIV = CLK_FREQ_HZ/TICK_HZ, must be ≥2.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous, active-high reset
- BUS_ADDR  input  8  CPU address bus
- BUS_DATA  inout  8  CPU data bus; tri-stated unless this block is answering a read
- BUS_WE  input  1  bus write strobe, sampled on CLK rising edge
- BUS_INTERRUPT_RAISE  output  1  high while any enabled pending flag is set
- BUS_INTERRUPT_ACK  input  1  one-cycle acknowledge from the CPU

Behaviour:
- One clock domain; reset is synchronous and active-high, so state is sampled on the CLK rising edge with RST=1.
- Reset values: all CTRL, PERIOD, COUNT and PENDING bits = 0; COUNT_HI shadow = 0; prescaler = 0; BUS_DATA = Z; BUS_INTERRUPT_RAISE = 0.
- Reset asserted mid-count or mid-read clears all state at that edge. The bus is released the following cycle.
- Prescaler: counts 0..DIV-1 and wraps. The tick is a one-cycle pulse when prescaler == DIV-1. It always runs, independent of channel enables.
- Register map, channel ch at A = BASE_ADDR + 4*ch:
  - A+0 CTRL (R/W): [0] EN, [1] MODE (0 one-shot, 1 periodic), [2] IE, [3] RELOAD (write-only strobe, reads 0), [7:4] read 0.
  - A+1 PERIOD_LO (R/W).
  - A+2 PERIOD_HI (R/W).
  - A+3 COUNT_LO (R). A read also copies COUNT[15:8] into the COUNT_HI shadow.
- Global registers, G = BASE_ADDR + 4*NUM_CH:
  - G+0 PENDING (R; write-1-to-clear). Bit ch = channel ch; bits ≥ NUM_CH read 0.
  - G+1 COUNT_HI shadow (R).
- Addresses outside BASE_ADDR..G+1 are ignored: no drive, no write. Writes to read-only registers are ignored.
- Read timing:
  - With BUS_WE=0 and an in-range address at edge N, read data and output enable are registered.
  - BUS_DATA is driven during cycle N+1 only, then returns to Z.
  - The read reflects register state before edge N.
- Write timing: with BUS_WE=1, the register updates at that edge.
- Loading COUNT:
  - COUNT loads PERIOD at the edge where a write sets EN from 0 to 1, or writes RELOAD=1.
  - Writing PERIOD alone does not change COUNT.
  - PERIOD=0 is treated as 1.
- Counting: on each tick with EN=1, COUNT decrements.
- Expiry: a decrement from 1 to 0, or a tick when COUNT==0 with EN=1.
  - Sets PENDING[ch], regardless of IE.
  - Periodic mode: COUNT reloads max(PERIOD,1) at the same edge, so expiry repeats every max(PERIOD,1) ticks.
  - One-shot mode: EN clears and COUNT holds 0.
- EN=0 freezes COUNT.
- BUS_INTERRUPT_RAISE = OR over ch of (PENDING[ch] & IE[ch]), registered: valid one cycle after the PENDING/IE change.
- BUS_INTERRUPT_ACK=1 clears every PENDING bit that has its IE set.
- Simultaneous events:
  - Expiry and ACK, or expiry and W1C, on the same bit at the same edge: set wins.
  - RELOAD or EN rising write on the same edge as a tick: the load wins, with no decrement and no expiry.
  - A CTRL write on the same edge as a one-shot expiry: the written EN value wins; PENDING is still set.
- Channels are fully independent. Several channels may expire on the same tick; each sets its own PENDING bit.

Test Plan (CLK_FREQ_HZ=1000, TICK_HZ=100 → DIV=10; BASE_ADDR=8'hD0, NUM_CH=4):
- Reset: hold RST 3 cycles → BUS_DATA=Z, RAISE=0; reading 0xD0..0xDF and 0xE0/0xE1 returns 8'h00 one cycle after the address.
- Periodic: ch1 PERIOD=3 (0xD5=3, 0xD6=0), CTRL 0xD4=8'h07 → PENDING (0xE0) bit1 set every 3 ticks (30 cycles), first expiry within 21..30 cycles of the write. RAISE high one cycle later. ACK pulse → RAISE low. Next expiry → RAISE high again.
- One-shot: ch0 PERIOD=16'h0102, CTRL=8'h05 → exactly one expiry after 258 ticks. CTRL reads 8'h04 (EN cleared). COUNT_LO reads 0. No further PENDING.
- Atomic count: ch2 PERIOD=16'h0300 running; read 0xDB then 0xE1 → {0xE1,0xDB} equals the count at the 0xDB read, even across a tick between the two reads.
- Masking and W1C: ch3 IE=0 expires → PENDING bit3=1, RAISE=0. ACK leaves bit3 set. Writing 0xE0=8'h08 clears it. Expiry on the same edge as the W1C → bit stays 1.
- Reset mid-operation: RST for 1 cycle during a periodic count → all registers read 0, RAISE=0, no further expiries until reprogrammed.
